// File: rtl/hazard_ctrl.sv
// DEC-stage hazard controller: in-flight writer scoreboard, operand forwarding
// selects, load-use / mul-div stalls, and taken-branch flush.
module hazard_ctrl #(
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_HazardCtrl_decValid,
  input  logic [4:0]       i_HazardCtrl_ra1,
  input  logic [4:0]       i_HazardCtrl_ra2,
  input  logic             i_HazardCtrl_use1,
  input  logic             i_HazardCtrl_use2,
  input  logic             i_HazardCtrl_regWe,
  input  logic [4:0]       i_HazardCtrl_WRA,
  input  logic             i_HazardCtrl_isLoad,
  input  logic             i_HazardCtrl_mdStart,
  input  logic             i_HazardCtrl_useHiLo,
  input  logic             i_HazardCtrl_brTaken,
  output logic             o_HazardCtrl_pauseF,
  output logic             o_HazardCtrl_pauseD,
  output logic             o_HazardCtrl_clrD,
  output logic             o_HazardCtrl_bubbleE,
  output logic [1:0]       o_HazardCtrl_fwdA,
  output logic [1:0]       o_HazardCtrl_fwdB,
  output logic             o_HazardCtrl_mdBusy,
  output logic [CNT_W-1:0] o_HazardCtrl_stallCnt
);

  localparam int MDC_W = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
  localparam logic [MDC_W-1:0] MD_LOAD = MDC_W'(MD_LAT - 1);

  typedef struct packed {
    logic       valid;
    logic [4:0] wa;
    logic       load;
  } sb_entry_t;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  sb_entry_t        sb_e, sb_m, sb_w;
  sb_entry_t        dec_entry;
  md_state_t        state, state_nxt;
  logic [MDC_W-1:0] md_cnt, md_cnt_nxt;
  logic             load_use, md_haz, stall, md_issue;
  logic [CNT_W-1:0] stall_cnt;

  // Register r0 is hard-wired zero, so it never produces a hazard.
  function automatic logic sb_match(input sb_entry_t x, input logic [4:0] a);
    return x.valid && (x.wa == a) && (a != 5'd0);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic use_op, input logic [4:0] a,
                                         input sb_entry_t e, input sb_entry_t m,
                                         input sb_entry_t w);
    logic [1:0] sel;
    sel = 2'd0;
    if (use_op) begin
      if (sb_match(e, a) && !e.load) sel = 2'd1;
      else if (sb_match(m, a))       sel = 2'd2;
      else if (sb_match(w, a))       sel = 2'd3;
    end
    return sel;
  endfunction

  always_comb begin
    load_use = i_HazardCtrl_decValid && sb_e.valid && sb_e.load &&
               ((i_HazardCtrl_use1 && sb_match(sb_e, i_HazardCtrl_ra1)) ||
                (i_HazardCtrl_use2 && sb_match(sb_e, i_HazardCtrl_ra2)));
    md_haz   = (state == MD_BUSY) && i_HazardCtrl_decValid &&
               (i_HazardCtrl_mdStart || i_HazardCtrl_useHiLo);
    stall    = load_use || md_haz;
    md_issue = (state == IDLE) && i_HazardCtrl_decValid && i_HazardCtrl_mdStart &&
               !stall && !i_HazardCtrl_brTaken;
  end

  // A taken branch outranks any stall: the DEC instruction is wrong-path anyway.
  always_comb begin
    o_HazardCtrl_pauseF  = 1'b0;
    o_HazardCtrl_pauseD  = 1'b0;
    o_HazardCtrl_clrD    = 1'b0;
    o_HazardCtrl_bubbleE = 1'b0;
    if (i_HazardCtrl_brTaken) begin
      o_HazardCtrl_clrD    = 1'b1;
      o_HazardCtrl_bubbleE = 1'b1;
    end else if (stall) begin
      o_HazardCtrl_pauseF  = 1'b1;
      o_HazardCtrl_pauseD  = 1'b1;
      o_HazardCtrl_bubbleE = 1'b1;
    end
  end

  always_comb begin
    o_HazardCtrl_fwdA = fwd_sel(i_HazardCtrl_use1, i_HazardCtrl_ra1, sb_e, sb_m, sb_w);
    o_HazardCtrl_fwdB = fwd_sel(i_HazardCtrl_use2, i_HazardCtrl_ra2, sb_e, sb_m, sb_w);
  end

  always_comb begin
    dec_entry.valid = i_HazardCtrl_decValid && i_HazardCtrl_regWe;
    dec_entry.wa    = i_HazardCtrl_WRA;
    dec_entry.load  = i_HazardCtrl_isLoad;
  end

  // Mul/div occupancy: a branch does not abort an operation already issued.
  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    case (state)
      IDLE: begin
        if (md_issue) begin
          state_nxt  = MD_BUSY;
          md_cnt_nxt = MD_LOAD;
        end
      end
      MD_BUSY: begin
        if (md_cnt == '0) state_nxt  = IDLE;
        else              md_cnt_nxt = md_cnt - MDC_W'(1);
      end
      default: begin
        state_nxt  = IDLE;
        md_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      md_cnt    <= '0;
      sb_e      <= '0;
      sb_m      <= '0;
      sb_w      <= '0;
      stall_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
      sb_w   <= sb_m;
      sb_m   <= sb_e;
      sb_e   <= o_HazardCtrl_bubbleE ? sb_entry_t'('0) : dec_entry;
      if (o_HazardCtrl_pauseD) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign o_HazardCtrl_mdBusy   = (state == MD_BUSY);
  assign o_HazardCtrl_stallCnt = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, mul/div busy,
// branch flush and asynchronous reset, with hand-computed expectations.
module tb_hazard_ctrl;
  logic        clk;
  logic        rstn;
  logic        dec_valid, use1, use2, reg_we, is_load, md_start, use_hilo, br_taken;
  logic [4:0]  ra1, ra2, wra;
  logic        pause_f, pause_d, clr_d, bubble_e, md_busy;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_ctrl #(.MD_LAT(4), .CNT_W(32)) dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .i_HazardCtrl_decValid (dec_valid),
    .i_HazardCtrl_ra1      (ra1),
    .i_HazardCtrl_ra2      (ra2),
    .i_HazardCtrl_use1     (use1),
    .i_HazardCtrl_use2     (use2),
    .i_HazardCtrl_regWe    (reg_we),
    .i_HazardCtrl_WRA      (wra),
    .i_HazardCtrl_isLoad   (is_load),
    .i_HazardCtrl_mdStart  (md_start),
    .i_HazardCtrl_useHiLo  (use_hilo),
    .i_HazardCtrl_brTaken  (br_taken),
    .o_HazardCtrl_pauseF   (pause_f),
    .o_HazardCtrl_pauseD   (pause_d),
    .o_HazardCtrl_clrD     (clr_d),
    .o_HazardCtrl_bubbleE  (bubble_e),
    .o_HazardCtrl_fwdA     (fwd_a),
    .o_HazardCtrl_fwdB     (fwd_b),
    .o_HazardCtrl_mdBusy   (md_busy),
    .o_HazardCtrl_stallCnt (stall_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after the rising edge, outputs
  // are checked 1 unit later, well before the next edge.
  task automatic drive(input logic v, input logic [4:0] a1, input logic u1,
                       input logic [4:0] a2, input logic u2, input logic we,
                       input logic [4:0] wa, input logic ld, input logic md,
                       input logic hl, input logic br);
    dec_valid = v;  ra1 = a1; use1 = u1; ra2 = a2; use2 = u2; reg_we = we;
    wra = wa; is_load = ld; md_start = md; use_hilo = hl; br_taken = br;
    #1;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    nop();
    repeat (3) tick();
  endtask

  task automatic apply_reset();
    nop();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    nop();
    tick();
    n_checks++; if (pause_f !== 1'b0)   begin n_fail++; $display("FAIL rst_pause_f: got %0b expected 0", pause_f); end
    n_checks++; if (pause_d !== 1'b0)   begin n_fail++; $display("FAIL rst_pause_d: got %0b expected 0", pause_d); end
    n_checks++; if (clr_d !== 1'b0)     begin n_fail++; $display("FAIL rst_clr_d: got %0b expected 0", clr_d); end
    n_checks++; if (bubble_e !== 1'b0)  begin n_fail++; $display("FAIL rst_bubble_e: got %0b expected 0", bubble_e); end
    n_checks++; if (fwd_a !== 2'd0)     begin n_fail++; $display("FAIL rst_fwd_a: got %0d expected 0", fwd_a); end
    n_checks++; if (fwd_b !== 2'd0)     begin n_fail++; $display("FAIL rst_fwd_b: got %0d expected 0", fwd_b); end
    n_checks++; if (md_busy !== 1'b0)   begin n_fail++; $display("FAIL rst_md_busy: got %0b expected 0", md_busy); end
    n_checks++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_stall_cnt: got %0d expected 0", stall_cnt); end
    rstn = 1'b1;
    tick();
  endtask

  // lw r8 ; add r9,r8,r8
  task automatic test_load_use();
    drive(1, 0, 0, 0, 0, 1, 8, 1, 0, 0, 0);
    n_checks++; if (pause_d !== 1'b0) begin n_fail++; $display("FAIL lu_lw_pause_d: got %0b expected 0", pause_d); end
    tick();
    drive(1, 8, 1, 8, 1, 1, 9, 0, 0, 0, 0);
    n_checks++; if (pause_f !== 1'b1)  begin n_fail++; $display("FAIL lu_pause_f: got %0b expected 1", pause_f); end
    n_checks++; if (pause_d !== 1'b1)  begin n_fail++; $display("FAIL lu_pause_d: got %0b expected 1", pause_d); end
    n_checks++; if (bubble_e !== 1'b1) begin n_fail++; $display("FAIL lu_bubble_e: got %0b expected 1", bubble_e); end
    n_checks++; if (clr_d !== 1'b0)    begin n_fail++; $display("FAIL lu_clr_d: got %0b expected 0", clr_d); end
    tick();
    n_checks++; if (pause_d !== 1'b0)    begin n_fail++; $display("FAIL lu_after_pause_d: got %0b expected 0", pause_d); end
    n_checks++; if (fwd_a !== 2'd2)      begin n_fail++; $display("FAIL lu_after_fwd_a: got %0d expected 2", fwd_a); end
    n_checks++; if (fwd_b !== 2'd2)      begin n_fail++; $display("FAIL lu_after_fwd_b: got %0d expected 2", fwd_b); end
    n_checks++; if (stall_cnt !== 32'd1) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d expected 1", stall_cnt); end
    tick();
    flush();
  endtask

  task automatic test_forwarding();
    // add r3 ; sub r4,r3,r5 ; or r6,r3,r3
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
    tick();
    drive(1, 3, 1, 5, 1, 1, 4, 0, 0, 0, 0);
    n_checks++; if (fwd_a !== 2'd1)   begin n_fail++; $display("FAIL fw_sub_fwd_a: got %0d expected 1", fwd_a); end
    n_checks++; if (fwd_b !== 2'd0)   begin n_fail++; $display("FAIL fw_sub_fwd_b: got %0d expected 0", fwd_b); end
    n_checks++; if (pause_d !== 1'b0) begin n_fail++; $display("FAIL fw_sub_pause_d: got %0b expected 0", pause_d); end
    tick();
    drive(1, 3, 1, 3, 1, 1, 6, 0, 0, 0, 0);
    n_checks++; if (fwd_a !== 2'd2) begin n_fail++; $display("FAIL fw_or_fwd_a: got %0d expected 2", fwd_a); end
    n_checks++; if (fwd_b !== 2'd2) begin n_fail++; $display("FAIL fw_or_fwd_b: got %0d expected 2", fwd_b); end
    tick();
    flush();
    // two writers of r3 back to back; newest in E wins
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
    tick();
    drive(1, 3, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (fwd_a !== 2'd1) begin n_fail++; $display("FAIL fw_b2b_fwd_a: got %0d expected 1", fwd_a); end
    n_checks++; if (fwd_b !== 2'd0) begin n_fail++; $display("FAIL fw_nouse_fwd_b: got %0d expected 0", fwd_b); end
    tick();
    flush();
    // writer r7, two bubbles, reader r7 picks WB
    drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
    tick();
    nop();
    tick();
    tick();
    drive(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
    n_checks++; if (fwd_b !== 2'd3) begin n_fail++; $display("FAIL fw_wb_fwd_b: got %0d expected 3", fwd_b); end
    tick();
    flush();
  endtask

  task automatic test_r0_and_invalid();
    // load to r0 then reader of r0: no forward, no stall
    drive(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    tick();
    drive(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    n_checks++; if (fwd_a !== 2'd0)   begin n_fail++; $display("FAIL r0_fwd_a: got %0d expected 0", fwd_a); end
    n_checks++; if (pause_d !== 1'b0) begin n_fail++; $display("FAIL r0_pause_d: got %0b expected 0", pause_d); end
    tick();
    flush();
    // load r8 with decValid=0 enters nothing
    drive(0, 0, 0, 0, 0, 1, 8, 1, 1, 0, 0);
    n_checks++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL inv_md_busy: got %0b expected 0", md_busy); end
    tick();
    drive(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (pause_d !== 1'b0)    begin n_fail++; $display("FAIL inv_pause_d: got %0b expected 0", pause_d); end
    n_checks++; if (fwd_a !== 2'd0)      begin n_fail++; $display("FAIL inv_fwd_a: got %0d expected 0", fwd_a); end
    n_checks++; if (md_busy !== 1'b0)    begin n_fail++; $display("FAIL inv_md_busy2: got %0b expected 0", md_busy); end
    n_checks++; if (stall_cnt !== 32'd1) begin n_fail++; $display("FAIL inv_stall_cnt: got %0d expected 1", stall_cnt); end
    tick();
    flush();
  endtask

  // MD_LAT=4: mult ; mfhi r10
  task automatic test_mul_div();
    apply_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    n_checks++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL md_issue_busy: got %0b expected 0", md_busy); end
    n_checks++; if (pause_d !== 1'b0) begin n_fail++; $display("FAIL md_issue_pause_d: got %0b expected 0", pause_d); end
    tick();
    drive(1, 0, 0, 0, 0, 1, 10, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (md_busy !== 1'b1) begin n_fail++; $display("FAIL md_busy_c%0d: got %0b expected 1", i, md_busy); end
      n_checks++; if (pause_d !== 1'b1) begin n_fail++; $display("FAIL md_pause_d_c%0d: got %0b expected 1", i, pause_d); end
      n_checks++; if (pause_f !== 1'b1) begin n_fail++; $display("FAIL md_pause_f_c%0d: got %0b expected 1", i, pause_f); end
      tick();
    end
    n_checks++; if (md_busy !== 1'b0)    begin n_fail++; $display("FAIL md_done_busy: got %0b expected 0", md_busy); end
    n_checks++; if (pause_d !== 1'b0)    begin n_fail++; $display("FAIL md_done_pause_d: got %0b expected 0", pause_d); end
    n_checks++; if (stall_cnt !== 32'd4) begin n_fail++; $display("FAIL md_stall_cnt: got %0d expected 4", stall_cnt); end
    tick();
    flush();
  endtask

  task automatic test_branch();
    // lw r8 ; add r9,r8,r8 while branch taken
    drive(1, 0, 0, 0, 0, 1, 8, 1, 0, 0, 0);
    tick();
    drive(1, 8, 1, 8, 1, 1, 9, 0, 0, 0, 1);
    n_checks++; if (clr_d !== 1'b1)    begin n_fail++; $display("FAIL br_clr_d: got %0b expected 1", clr_d); end
    n_checks++; if (bubble_e !== 1'b1) begin n_fail++; $display("FAIL br_bubble_e: got %0b expected 1", bubble_e); end
    n_checks++; if (pause_f !== 1'b0)  begin n_fail++; $display("FAIL br_pause_f: got %0b expected 0", pause_f); end
    n_checks++; if (pause_d !== 1'b0)  begin n_fail++; $display("FAIL br_pause_d: got %0b expected 0", pause_d); end
    tick();
    n_checks++; if (stall_cnt !== 32'd4) begin n_fail++; $display("FAIL br_stall_cnt: got %0d expected 4", stall_cnt); end
    // wrong-path mult
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    tick();
    nop();
    n_checks++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL br_md_busy: got %0b expected 0", md_busy); end
    tick();
    n_checks++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL br_md_busy2: got %0b expected 0", md_busy); end
    flush();
  endtask

  task automatic test_reset_mid_busy();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    n_checks++; if (md_busy !== 1'b1) begin n_fail++; $display("FAIL rb_busy_br: got %0b expected 1", md_busy); end
    tick();
    nop();
    n_checks++; if (md_busy !== 1'b1) begin n_fail++; $display("FAIL rb_busy_cnt2: got %0b expected 1", md_busy); end
    rstn = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    n_checks++; if (md_busy !== 1'b0)    begin n_fail++; $display("FAIL rb_low_busy: got %0b expected 0", md_busy); end
    n_checks++; if (pause_f !== 1'b0)    begin n_fail++; $display("FAIL rb_low_pause_f: got %0b expected 0", pause_f); end
    n_checks++; if (pause_d !== 1'b0)    begin n_fail++; $display("FAIL rb_low_pause_d: got %0b expected 0", pause_d); end
    n_checks++; if (bubble_e !== 1'b0)   begin n_fail++; $display("FAIL rb_low_bubble_e: got %0b expected 0", bubble_e); end
    n_checks++; if (clr_d !== 1'b0)      begin n_fail++; $display("FAIL rb_low_clr_d: got %0b expected 0", clr_d); end
    n_checks++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL rb_low_stall_cnt: got %0d expected 0", stall_cnt); end
    tick();
    n_checks++; if (md_busy !== 1'b0)    begin n_fail++; $display("FAIL rb_low2_busy: got %0b expected 0", md_busy); end
    n_checks++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL rb_low2_stall_cnt: got %0d expected 0", stall_cnt); end
    rstn = 1'b1;
    #1;
    n_checks++; if (pause_d !== 1'b0) begin n_fail++; $display("FAIL rb_rel_pause_d: got %0b expected 0", pause_d); end
    tick();
    n_checks++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL rb_rel_stall_cnt: got %0d expected 0", stall_cnt); end
    n_checks++; if (md_busy !== 1'b0)    begin n_fail++; $display("FAIL rb_rel_busy: got %0b expected 0", md_busy); end
    nop();
    tick();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forwarding();
    test_r0_and_invalid();
    test_mul_div();
    test_branch();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
